// File: rtl/isa_pkg.sv
// ISA constants shared by the decode stage and its register file.
// Opcode values, instruction field positions, FSM encoding and opcode classifiers.
package isa_pkg;

  localparam int OPC_W  = 5;
  localparam int REG_AW = 3;
  localparam int DATA_W = 16;
  localparam int OPND_W = DATA_W + 1;

  localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_IADD = 5'b01110;
  localparam logic [OPC_W-1:0] OP_LDM  = 5'b10100;
  localparam logic [OPC_W-1:0] OP_STD  = 5'b10110;
  localparam logic [OPC_W-1:0] OP_PUSH = 5'b11000;
  localparam logic [OPC_W-1:0] OP_POP  = 5'b11001;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;
  localparam int RDST_MSB = 10;
  localparam int RDST_LSB = 8;
  localparam int RSRC_MSB = 7;
  localparam int RSRC_LSB = 5;

  localparam logic [0:0] S_DECODE = 1'b0;
  localparam logic [0:0] S_IMM    = 1'b1;

  // All-zero value of this struct is the NOP bundle.
  typedef struct packed {
    logic              st;
    logic              sst;
    logic [OPND_W-1:0] reg1;
    logic [OPND_W-1:0] reg2;
    logic [OPC_W-1:0]  instr;
    logic [REG_AW-1:0] src;
    logic [REG_AW-1:0] rdst;
  } bundle_t;

  function automatic logic is_immediate(input logic [OPC_W-1:0] op);
    return (op == OP_LDM) || (op == OP_IADD);
  endfunction

  function automatic logic is_store(input logic [OPC_W-1:0] op);
    return (op == OP_STD) || (op == OP_PUSH);
  endfunction

  function automatic logic is_stack(input logic [OPC_W-1:0] op);
    return (op == OP_PUSH) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch / write-back inputs and operand bundle outputs of the decode stage.
// master drives words and write-backs; slave is the decode stage itself.
interface decode_stage_if;
  import isa_pkg::*;

  logic [DATA_W-1:0] InstrIn;
  logic              InstrValid;
  logic              Stall;
  logic              Flush;
  logic              WBEnable;
  logic [REG_AW-1:0] WBAddress;
  logic [DATA_W-1:0] WBData;
  logic              ST;
  logic              SST;
  logic [OPND_W-1:0] Reg1;
  logic [OPND_W-1:0] Reg2;
  logic [OPC_W-1:0]  Instruction;
  logic [REG_AW-1:0] SrcAddress;
  logic [REG_AW-1:0] RegDestination;

  modport master (
    output InstrIn, InstrValid, Stall, Flush, WBEnable, WBAddress, WBData,
    input  ST, SST, Reg1, Reg2, Instruction, SrcAddress, RegDestination
  );

  modport slave (
    input  InstrIn, InstrValid, Stall, Flush, WBEnable, WBAddress, WBData,
    output ST, SST, Reg1, Reg2, Instruction, SrcAddress, RegDestination
  );

endinterface

// File: rtl/regfile_8x16.sv
// 8x16 general register file: one write port, two combinational read ports
// that forward the write-back value when it targets the register being read.
module regfile_8x16
  import isa_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [8];

  // Async clear of every entry rules out a RAM; each register is its own flop bank.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          q_reg <= '0;
        end else if (we && (waddr == REG_AW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
  assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: turns instruction words into a registered operand/control bundle,
// assembling two-word immediate instructions and honouring flush and stall.
module decode_stage
  import isa_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst,
  decode_stage_if.slave  dif
);

  logic [0:0]        state_reg, state_next;
  logic [OPC_W-1:0]  lat_op_reg, lat_op_next;
  logic [REG_AW-1:0] lat_rdst_reg, lat_rdst_next;
  logic [REG_AW-1:0] lat_rsrc_reg, lat_rsrc_next;
  bundle_t           out_reg, out_next;

  logic [OPC_W-1:0]  op_in;
  logic [REG_AW-1:0] rdst_in, rsrc_in;
  logic [REG_AW-1:0] raddr1, raddr2;
  logic [DATA_W-1:0] rdata1, rdata2;

  assign op_in   = dif.InstrIn[OP_MSB:OP_LSB];
  assign rdst_in = dif.InstrIn[RDST_MSB:RDST_LSB];
  assign rsrc_in = dif.InstrIn[RSRC_MSB:RSRC_LSB];

  // The second word of an immediate instruction carries no register fields.
  assign raddr1 = (state_reg == S_IMM) ? lat_rsrc_reg : rsrc_in;
  assign raddr2 = (state_reg == S_IMM) ? lat_rdst_reg : rdst_in;

  regfile_8x16 u_regfile (
    .Clk    (Clk),
    .Rst    (Rst),
    .we     (dif.WBEnable),
    .waddr  (dif.WBAddress),
    .wdata  (dif.WBData),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always_comb begin
    state_next    = state_reg;
    lat_op_next   = lat_op_reg;
    lat_rdst_next = lat_rdst_reg;
    lat_rsrc_next = lat_rsrc_reg;
    out_next      = '0;
    if (dif.InstrValid) begin
      if (state_reg == S_DECODE) begin
        if (is_immediate(op_in)) begin
          lat_op_next   = op_in;
          lat_rdst_next = rdst_in;
          lat_rsrc_next = rsrc_in;
          state_next    = S_IMM;
        end else begin
          out_next.st    = is_store(op_in);
          out_next.sst   = is_stack(op_in);
          out_next.reg1  = {1'b0, rdata1};
          out_next.reg2  = {1'b0, rdata2};
          out_next.instr = op_in;
          out_next.src   = rsrc_in;
          out_next.rdst  = rdst_in;
        end
      end else begin
        out_next.st    = is_store(lat_op_reg);
        out_next.sst   = is_stack(lat_op_reg);
        out_next.reg1  = {1'b0, rdata1};
        out_next.reg2  = {1'b1, dif.InstrIn};
        out_next.instr = lat_op_reg;
        out_next.src   = lat_rsrc_reg;
        out_next.rdst  = lat_rdst_reg;
        state_next     = S_DECODE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg    <= S_DECODE;
      lat_op_reg   <= OP_NOP;
      lat_rdst_reg <= '0;
      lat_rsrc_reg <= '0;
      out_reg      <= '0;
    end else if (dif.Flush) begin
      state_reg    <= S_DECODE;
      lat_op_reg   <= OP_NOP;
      lat_rdst_reg <= '0;
      lat_rsrc_reg <= '0;
      out_reg      <= '0;
    end else if (!dif.Stall) begin
      state_reg    <= state_next;
      lat_op_reg   <= lat_op_next;
      lat_rdst_reg <= lat_rdst_next;
      lat_rsrc_reg <= lat_rsrc_next;
      out_reg      <= out_next;
    end
  end

  assign dif.ST             = out_reg.st;
  assign dif.SST            = out_reg.sst;
  assign dif.Reg1           = out_reg.reg1;
  assign dif.Reg2           = out_reg.reg2;
  assign dif.Instruction    = out_reg.instr;
  assign dif.SrcAddress     = out_reg.src;
  assign dif.RegDestination = out_reg.rdst;

endmodule
